// File: rtl/parking_controller.sv
// Parking-lot gate controller: PIN-gated entry, wrong-PIN alarm and tailgating lock.
// Optional PARKING_GATE_ACK_EN: CLOSING waits for gate_ack instead of lasting one cycle.
//
// state     | meaning
// IDLE      | no vehicle, gate closed
// WAIT_CODE | vehicle at gate, waiting for PIN
// OPEN      | gate commanded open
// CLOSING   | gate commanded closed after vehicle passed
// BLOCKED   | tailgating detected, gate locked until correct PIN
`default_nettype none

module parking_controller #(
  parameter logic [15:0] PIN          = 16'h5990,
  parameter int          MAX_ATTEMPTS = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        vehicle_arrival,
  input  logic        vehicle_left,
  input  logic [15:0] code,
  input  logic        code_ack,
  input  logic        gate_ack,
  output logic        open_gate,
  output logic        close_gate,
  output logic        wrong_ping,
  output logic        blocked_gate
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] WAIT_CODE = 3'd1;
  localparam logic [2:0] OPEN      = 3'd2;
  localparam logic [2:0] CLOSING   = 3'd3;
  localparam logic [2:0] BLOCKED   = 3'd4;

  logic [2:0] state, state_nxt;
  logic [1:0] att, att_nxt;
  logic       pin_ok;

  assign pin_ok = code_ack && (code == PIN);

  always_comb begin
    state_nxt = state;
    att_nxt   = att;
    case (state)
      IDLE: begin
        if (vehicle_arrival) state_nxt = WAIT_CODE;
      end
      WAIT_CODE: begin
        if (pin_ok) begin
          state_nxt = OPEN;
          att_nxt   = 2'd0;
        end else if (code_ack && att != 2'd3) begin
          att_nxt = att + 2'd1;
        end
      end
      OPEN: begin
        if (vehicle_left) state_nxt = vehicle_arrival ? BLOCKED : CLOSING;
      end
      CLOSING: begin
        // tailgating takes priority over finishing the close
        if (vehicle_arrival && vehicle_left) begin
          state_nxt = BLOCKED;
        end else begin
`ifdef PARKING_GATE_ACK_EN
          if (gate_ack) state_nxt = IDLE;
`else
          state_nxt = IDLE;
`endif
        end
      end
      BLOCKED: begin
        if (pin_ok) begin
          state_nxt = OPEN;
          att_nxt   = 2'd0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifndef PARKING_GATE_ACK_EN
  logic unused_gate_ack;
  assign unused_gate_ack = gate_ack;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      att   <= 2'd0;
    end else begin
      state <= state_nxt;
      att   <= att_nxt;
    end
  end

  assign open_gate    = (state == OPEN);
  assign close_gate   = (state == CLOSING) || (state == BLOCKED);
  assign blocked_gate = (state == BLOCKED);
  assign wrong_ping   = (state == WAIT_CODE) && (int'(att) >= MAX_ATTEMPTS);

endmodule

`default_nettype wire

// File: tb/tb_parking_controller.sv
// Directed self-checking bench for parking_controller (default build).
`timescale 1ns/1ps

module tb_parking_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        vehicle_arrival = 1'b0;
  logic        vehicle_left = 1'b0;
  logic [15:0] code = 16'h0000;
  logic        code_ack = 1'b0;
  logic        gate_ack = 1'b0;
  logic        open_gate, close_gate, wrong_ping, blocked_gate;

  int errors = 0;
  int checks = 0;

  parking_controller dut (
    .clk(clk), .rst(rst),
    .vehicle_arrival(vehicle_arrival), .vehicle_left(vehicle_left),
    .code(code), .code_ack(code_ack), .gate_ack(gate_ack),
    .open_gate(open_gate), .close_gate(close_gate),
    .wrong_ping(wrong_ping), .blocked_gate(blocked_gate)
  );

  always #5 clk = ~clk;

  // outputs packed as {open, close, wrong, blocked}
  task automatic chk(input string tag, input logic [3:0] exp);
    logic [3:0] obs;
    obs = {open_gate, close_gate, wrong_ping, blocked_gate};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_code(input logic [15:0] c);
    code = c;
    code_ack = 1'b1;
    tick();
    code_ack = 1'b0;
  endtask

  task automatic arrive();
    vehicle_arrival = 1'b1;
    tick();
    vehicle_arrival = 1'b0;
  endtask

  initial begin
    tick();
    chk("reset", 4'b0000);
    rst = 1'b0;
    tick();
    chk("idle_after_reset", 4'b0000);

    // normal entry and exit
    arrive();
    chk("wait_code", 4'b0000);
    send_code(16'h5990);
    chk("open_on_pin", 4'b1000);
    vehicle_left = 1'b1;
    tick();
    vehicle_left = 1'b0;
    chk("closing", 4'b0100);
    gate_ack = 1'b1;
    tick();
    gate_ack = 1'b0;
    chk("idle_after_close", 4'b0000);

    // asynchronous reset mid-OPEN
    arrive();
    send_code(16'h5990);
    chk("open_before_rst", 4'b1000);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_immediate", 4'b0000);
    rst = 1'b0;
    tick();
    chk("idle_after_rst", 4'b0000);
    send_code(16'h5990);
    chk("code_ignored_idle", 4'b0000);

    // wrong-PIN alarm and saturation
    arrive();
    for (int i = 0; i < 3; i++) begin
      send_code(16'h1234);
      chk($sformatf("wrong_%0d", i + 1), (i == 2) ? 4'b0010 : 4'b0000);
    end
    send_code(16'h1234);
    chk("wrong_4_saturated", 4'b0010);
    send_code(16'h5990);
    chk("alarm_cleared_open", 4'b1000);

    // tailgating lock
    vehicle_arrival = 1'b1;
    vehicle_left = 1'b1;
    tick();
    vehicle_arrival = 1'b0;
    vehicle_left = 1'b0;
    chk("blocked", 4'b0101);
    send_code(16'h0000);
    chk("blocked_wrong_ignored", 4'b0101);
    vehicle_left = 1'b1;
    tick();
    vehicle_left = 1'b0;
    chk("blocked_sensor_ignored", 4'b0101);
    send_code(16'h5990);
    chk("unblocked_open", 4'b1000);

    // close pulse with gate_ack held low
    vehicle_left = 1'b1;
    tick();
    vehicle_left = 1'b0;
    chk("close_pulse", 4'b0100);
    tick();
`ifdef PARKING_GATE_ACK_EN
    chk("close_held", 4'b0100);
    gate_ack = 1'b1;
    tick();
    gate_ack = 1'b0;
`endif
    chk("close_one_cycle", 4'b0000);

    // attempt counter cleared by correct PIN
    arrive();
    send_code(16'h1111);
    send_code(16'h2222);
    chk("two_wrong", 4'b0000);
    send_code(16'h5990);
    chk("open_after_two_wrong", 4'b1000);
    vehicle_left = 1'b1;
    tick();
    vehicle_left = 1'b0;
    gate_ack = 1'b1;
    tick();
    gate_ack = 1'b0;
    chk("idle_again", 4'b0000);
    arrive();
    send_code(16'h1111);
    send_code(16'h1111);
    chk("fresh_two_wrong", 4'b0000);
    send_code(16'h1111);
    chk("fresh_third_wrong", 4'b0010);
    send_code(16'h5990);
    chk("open_again", 4'b1000);

    // code_ack held high counts one attempt per cycle
    vehicle_left = 1'b1;
    tick();
    vehicle_left = 1'b0;
    gate_ack = 1'b1;
    tick();
    gate_ack = 1'b0;
    arrive();
    code = 16'hbeef;
    code_ack = 1'b1;
    tick();
    tick();
    chk("held_ack_two", 4'b0000);
    tick();
    code_ack = 1'b0;
    chk("held_ack_three", 4'b0010);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
